// File: rtl/time_sync_phc_arb_pkg.sv
// Shared ToD field layout, state encoding and arbitration mode constants
// for the PHC write arbiter.
package time_sync_pkg;

  localparam int TS_W       = 96;
  localparam int S_LSB      = 48;
  localparam int S_W        = 48;
  localparam int NS_LSB     = 16;
  localparam int NS_W       = 30;
  localparam int NS_FIELD_W = 32;
  localparam int SLOT_W     = S_W + NS_W;

  localparam logic [NS_FIELD_W-1:0] NS_PER_S = 32'd1_000_000_000;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // The full 32-bit ns field is range-checked, not just the 30 bits written.
  function automatic logic ns_valid(input logic [TS_W-1:0] ts);
    return ts[NS_LSB +: NS_FIELD_W] < NS_PER_S;
  endfunction

endpackage

// File: rtl/time_sync_phc_arb_rr_arbiter.sv
// Combinational request arbiter: pending vector plus rotation pointer in,
// one-hot grant and binary index out. Fixed-priority mode ignores the pointer.
module time_sync_rr_arbiter
  import time_sync_pkg::*;
#(
  parameter int CH_COUNT     = 2,
  parameter int ARB_MODE     = ARB_RR,
  parameter int CH_IDX_WIDTH = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
  input  logic [CH_COUNT-1:0]     req_i,
  input  logic [CH_IDX_WIDTH-1:0] ptr_i,
  output logic [CH_COUNT-1:0]     gnt_o,
  output logic [CH_IDX_WIDTH-1:0] gnt_idx_o,
  output logic                    gnt_any_o
);

  int start_idx;
  int cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = 0;
    start_idx = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr_i);
    if (start_idx >= CH_COUNT) start_idx = 0;
    for (int k = 0; k < CH_COUNT; k++) begin
      cand = start_idx + k;
      if (cand >= CH_COUNT) cand = cand - CH_COUNT;
      if (!gnt_any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = CH_IDX_WIDTH'(cand);
        gnt_any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_sync_phc_arb.sv
// Funnels per-interface time-sync correction requests into the single PHC
// write port, with validation, arbitration, ack timeout, holdoff and counters.
module time_sync_phc_arb
  import time_sync_pkg::*;
#(
  parameter int CH_COUNT       = 2,
  parameter int ARB_MODE       = ARB_RR,
  parameter int HOLDOFF_CYCLES = 256,
  parameter int ACK_TIMEOUT    = 1024,
  parameter int CNT_WIDTH      = 16,
  parameter int CH_IDX_WIDTH   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CH_COUNT-1:0]        sync_wr_en,
  input  logic [CH_COUNT*TS_W-1:0]   sync_wr_ts,
  input  logic [CH_COUNT-1:0]        ch_enable,
  output logic                       time_sync_wr_en,
  output logic [NS_W-1:0]            time_sync_wr_ns,
  output logic [S_W-1:0]             time_sync_wr_s,
  input  logic                       time_sync_wr_ack,
  output logic [CH_COUNT-1:0]        pending,
  output logic                       busy,
  output logic [CH_IDX_WIDTH-1:0]    last_ch,
  output logic [CNT_WIDTH-1:0]       wr_count,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic [CNT_WIDTH-1:0]       invalid_count,
  output logic [CNT_WIDTH-1:0]       timeout_count
);

  // The IDLE arbitration cycle is the last low cycle of the holdoff gap,
  // so the HOLDOFF state itself lasts HOLDOFF_CYCLES-1 cycles.
  localparam int HO_LAST = (HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 2 : 0;
  localparam int TO_LAST = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 1 : 0;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [4:0] n);
    logic [CNT_WIDTH+5:0] s;
    s = {6'b0, c} + {{(CNT_WIDTH+1){1'b0}}, n};
    if (s > {6'b0, {CNT_WIDTH{1'b1}}}) return {CNT_WIDTH{1'b1}};
    return s[CNT_WIDTH-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [31:0]             tmr_q, tmr_d;
  logic [CH_COUNT-1:0]     pend_q, pend_d;
  logic [SLOT_W-1:0]       slot_q [CH_COUNT];
  logic [SLOT_W-1:0]       slot_d [CH_COUNT];
  logic [CH_IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [CH_IDX_WIDTH-1:0] last_ch_q, last_ch_d;
  logic [S_W-1:0]          wr_s_q, wr_s_d;
  logic [NS_W-1:0]         wr_ns_q, wr_ns_d;
  logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]    drop_q, drop_d;
  logic [CNT_WIDTH-1:0]    inv_q, inv_d;
  logic [CNT_WIDTH-1:0]    to_q, to_d;

  logic [CH_COUNT-1:0]     arb_req, gnt, taken;
  logic [CH_IDX_WIDTH-1:0] gnt_idx;
  logic                    gnt_any, grant_fire, ack_hit, to_hit;
  logic [SLOT_W-1:0]       sel_slot;
  logic [TS_W-1:0]         ts_ch;
  logic                    req_ok, req_bad;
  logic [4:0]              drop_n, inv_n;
  logic [CH_COUNT*16-1:0]  fns_unused;

  // A channel disabled this cycle must not win even if its flag is still set.
  assign arb_req = pend_q & ch_enable;

  time_sync_rr_arbiter #(
    .CH_COUNT    (CH_COUNT),
    .ARB_MODE    (ARB_MODE),
    .CH_IDX_WIDTH(CH_IDX_WIDTH)
  ) u_arb (
    .req_i    (arb_req),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_any_o(gnt_any)
  );

  assign grant_fire = (state_q == ST_IDLE) && gnt_any;
  assign taken      = gnt & {CH_COUNT{grant_fire}};

  always_comb begin
    sel_slot = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      sel_slot = sel_slot | (slot_q[i] & {SLOT_W{gnt[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ack_hit = 1'b0;
    to_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d = ST_WRITE;
          tmr_d   = '0;
        end
      end
      ST_WRITE: begin
        // Ack wins over a timeout expiring on the same cycle.
        if (time_sync_wr_ack) ack_hit = 1'b1;
        else if (tmr_q == 32'(TO_LAST)) to_hit = 1'b1;
        else tmr_d = tmr_q + 32'd1;
        if (ack_hit || to_hit) begin
          state_d = (HOLDOFF_CYCLES > 1) ? ST_HOLDOFF : ST_IDLE;
          tmr_d   = '0;
        end
      end
      ST_HOLDOFF: begin
        if (tmr_q == 32'(HO_LAST)) state_d = ST_IDLE;
        else tmr_d = tmr_q + 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    time_sync_wr_en = (state_q == ST_WRITE);
    busy            = (state_q != ST_IDLE);
  end

  always_comb begin
    pend_d     = pend_q;
    drop_n     = '0;
    inv_n      = '0;
    ts_ch      = '0;
    req_ok     = 1'b0;
    req_bad    = 1'b0;
    fns_unused = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      ts_ch   = sync_wr_ts[i*TS_W +: TS_W];
      fns_unused[i*16 +: 16] = ts_ch[15:0];
      req_ok  = sync_wr_en[i] && ch_enable[i] && ns_valid(ts_ch);
      req_bad = sync_wr_en[i] && ch_enable[i] && !ns_valid(ts_ch);
      slot_d[i] = req_ok ? {ts_ch[S_LSB +: S_W], ts_ch[NS_LSB +: NS_W]} : slot_q[i];
      if (!ch_enable[i]) begin
        pend_d[i] = 1'b0;
      end else if (req_ok) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !taken[i]) drop_n = drop_n + 5'd1;
      end else if (taken[i]) begin
        pend_d[i] = 1'b0;
      end
      if (req_bad) inv_n = inv_n + 5'd1;
    end
  end

  always_comb begin
    wr_s_d    = wr_s_q;
    wr_ns_d   = wr_ns_q;
    last_ch_d = last_ch_q;
    ptr_d     = ptr_q;
    if (grant_fire) begin
      wr_s_d    = sel_slot[SLOT_W-1 -: S_W];
      wr_ns_d   = sel_slot[NS_W-1:0];
      last_ch_d = gnt_idx;
      ptr_d     = (gnt_idx == CH_IDX_WIDTH'(CH_COUNT - 1)) ? '0
                                                           : gnt_idx + CH_IDX_WIDTH'(1);
    end
    wr_cnt_d = sat_add(wr_cnt_q, {4'b0, ack_hit});
    to_d     = sat_add(to_q, {4'b0, to_hit});
    drop_d   = sat_add(drop_q, drop_n);
    inv_d    = sat_add(inv_q, inv_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      ptr_q     <= '0;
      last_ch_q <= '0;
      wr_s_q    <= '0;
      wr_ns_q   <= '0;
      wr_cnt_q  <= '0;
      drop_q    <= '0;
      inv_q     <= '0;
      to_q      <= '0;
      for (int i = 0; i < CH_COUNT; i++) slot_q[i] <= '0;
    end else begin
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      last_ch_q <= last_ch_d;
      wr_s_q    <= wr_s_d;
      wr_ns_q   <= wr_ns_d;
      wr_cnt_q  <= wr_cnt_d;
      drop_q    <= drop_d;
      inv_q     <= inv_d;
      to_q      <= to_d;
      for (int i = 0; i < CH_COUNT; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign pending         = pend_q;
  assign last_ch         = last_ch_q;
  assign time_sync_wr_s  = wr_s_q;
  assign time_sync_wr_ns = wr_ns_q;
  assign wr_count        = wr_cnt_q;
  assign drop_count      = drop_q;
  assign invalid_count   = inv_q;
  assign timeout_count   = to_q;

endmodule

// File: tb/tb_time_sync_phc_arb.sv
// Bench for time_sync_phc_arb: directed scenarios on two configurations plus
// randomized traffic on the round-robin instance against a behavioural model.
module tb_time_sync_phc_arb;

  localparam int TO = 8;
  localparam logic [31:0] NSPS = 32'd1_000_000_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // Instance A: round-robin, no holdoff
  logic         rst_a, ack_a;
  logic [1:0]   req_a, en_a;
  logic [95:0]  ts_a [2];
  logic [191:0] ts_bus_a;
  logic         wr_en_a, busy_a;
  logic [29:0]  wr_ns_a;
  logic [47:0]  wr_s_a;
  logic [1:0]   pend_a;
  logic [0:0]   last_a;
  logic [15:0]  wrc_a, drop_a, inv_a, to_a;
  assign ts_bus_a = {ts_a[1], ts_a[0]};

  // Instance B: fixed priority, holdoff 4, 2-bit counters
  logic         rst_b, ack_b;
  logic [1:0]   req_b, en_b;
  logic [95:0]  ts_b [2];
  logic [191:0] ts_bus_b;
  logic         wr_en_b, busy_b;
  logic [29:0]  wr_ns_b;
  logic [47:0]  wr_s_b;
  logic [1:0]   pend_b;
  logic [0:0]   last_b;
  logic [1:0]   wrc_b, drop_b, inv_b, to_b;
  assign ts_bus_b = {ts_b[1], ts_b[0]};

  time_sync_phc_arb #(.CH_COUNT(2), .ARB_MODE(0), .HOLDOFF_CYCLES(0),
                      .ACK_TIMEOUT(TO), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_a), .sync_wr_en(req_a), .sync_wr_ts(ts_bus_a),
    .ch_enable(en_a), .time_sync_wr_en(wr_en_a), .time_sync_wr_ns(wr_ns_a),
    .time_sync_wr_s(wr_s_a), .time_sync_wr_ack(ack_a), .pending(pend_a),
    .busy(busy_a), .last_ch(last_a), .wr_count(wrc_a), .drop_count(drop_a),
    .invalid_count(inv_a), .timeout_count(to_a));

  time_sync_phc_arb #(.CH_COUNT(2), .ARB_MODE(1), .HOLDOFF_CYCLES(4),
                      .ACK_TIMEOUT(TO), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .sync_wr_en(req_b), .sync_wr_ts(ts_bus_b),
    .ch_enable(en_b), .time_sync_wr_en(wr_en_b), .time_sync_wr_ns(wr_ns_b),
    .time_sync_wr_s(wr_s_b), .time_sync_wr_ack(ack_b), .pending(pend_b),
    .busy(busy_b), .last_ch(last_b), .wr_count(wrc_b), .drop_count(drop_b),
    .invalid_count(inv_b), .timeout_count(to_b));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    nchk++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [95:0] mk_ts(input logic [47:0] s, input logic [31:0] ns,
                                        input logic [15:0] fns);
    return {s, ns, fns};
  endfunction

  function automatic logic [95:0] rand_ts();
    logic [31:0] ns;
    case ($urandom_range(0, 7))
      0:       ns = NSPS;
      1:       ns = NSPS - 32'd1;
      2:       ns = $urandom;
      default: ns = $urandom % NSPS;
    endcase
    return {16'($urandom), 32'($urandom), ns, 16'($urandom)};
  endfunction

  // Behavioural model of instance A: one write at a time, latest request per
  // channel wins, writes end on ack or after TO unacknowledged cycles.
  logic        m_writing;
  int          m_left, m_ptr, m_wrc, m_drop, m_inv, m_to;
  logic [1:0]  m_pend;
  logic [95:0] m_slot [2];
  logic [47:0] m_s;
  logic [29:0] m_ns;
  logic        m_last;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_step();
    int g;
    logic [1:0] live;
    g = -1;
    if (rst_a) begin
      m_writing = 1'b0; m_left = 0; m_ptr = 0; m_pend = '0; m_s = '0; m_ns = '0;
      m_last = 1'b0; m_wrc = 0; m_drop = 0; m_inv = 0; m_to = 0;
      m_slot[0] = '0; m_slot[1] = '0;
      return;
    end
    live = m_pend & en_a;
    if (!m_writing) begin
      if (live != 2'b00) begin
        g = live[m_ptr] ? m_ptr : 1 - m_ptr;
        m_s = m_slot[g][95:48];
        m_ns = m_slot[g][45:16];
        m_last = (g == 1);
        m_ptr = (g + 1) % 2;
        m_writing = 1'b1;
        m_left = TO;
      end
    end else if (ack_a) begin
      m_wrc = sat16(m_wrc + 1);
      m_writing = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_to = sat16(m_to + 1);
        m_writing = 1'b0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (!en_a[c]) begin
        m_pend[c] = 1'b0;
      end else if (req_a[c] && ts_a[c][47:16] < NSPS) begin
        if (m_pend[c] && g != c) m_drop = sat16(m_drop + 1);
        m_pend[c] = 1'b1;
        m_slot[c] = ts_a[c];
      end else begin
        if (req_a[c]) m_inv = sat16(m_inv + 1);
        if (g == c) m_pend[c] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_ctrl", {wr_en_a, busy_a, pend_a, last_a},
          {m_writing, m_writing, m_pend, m_last});
    check("model_data", {wr_s_a, wr_ns_a}, {m_s, m_ns});
    check("model_cnt", {wrc_a, drop_a, inv_a, to_a},
          {16'(m_wrc), 16'(m_drop), 16'(m_inv), 16'(m_to)});
  endtask

  task automatic wait_wr_a();
    int n;
    n = 0;
    while (!wr_en_a && n < 40) begin
      tick();
      n++;
    end
    check("wait_wr_a", wr_en_a, 1'b1);
  endtask

  task automatic ack_a_once();
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
  endtask

  initial begin
    int hi, lo;
    rst_a = 1'b1; rst_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
    req_a = '0; req_b = '0; en_a = '0; en_b = '0;
    ts_a[0] = '0; ts_a[1] = '0; ts_b[0] = '0; ts_b[1] = '0;
    tick(); tick();
    check("rst_a_state", {wr_en_a, busy_a, pend_a, last_a, wrc_a, drop_a, inv_a, to_a},
          '0);
    check("rst_a_data", {wr_s_a, wr_ns_a}, '0);
    check("rst_b_state", {wr_en_b, busy_b, pend_b, last_b, wrc_b, drop_b, inv_b, to_b,
                          wr_s_b, wr_ns_b}, '0);
    rst_a = 1'b0; rst_b = 1'b0;
    en_a = 2'b11; en_b = 2'b11;
    tick();

    // Single write latency: request in cycle N, pending N+1, wr_en N+2
    ts_a[0] = mk_ts(48'd5, 32'd123, 16'd0); req_a = 2'b01;
    tick(); req_a = 2'b00;
    check("lat_pend", {pend_a, wr_en_a}, {2'b01, 1'b0});
    tick();
    check("lat_wr", {wr_en_a, wr_s_a, wr_ns_a}, {1'b1, 48'd5, 30'd123});
    tick(); tick();
    check("lat_hold", {wr_en_a, wr_s_a, wr_ns_a}, {1'b1, 48'd5, 30'd123});
    ack_a_once();
    check("lat_done", {wr_en_a, wrc_a}, {1'b0, 16'd1});

    // Round-robin alternation with both channels requesting together
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int r = 0; r < 4; r++) begin
      ts_a[0] = mk_ts(48'(r), 32'(r * 10), 16'd0);
      ts_a[1] = mk_ts(48'(r), 32'(r * 10 + 1), 16'd0);
      req_a = 2'b11; tick(); req_a = 2'b00;
      for (int k = 0; k < 2; k++) begin
        wait_wr_a();
        check("rr_grant", {last_a, wr_ns_a}, {1'(k), 30'(r * 10 + k)});
        ack_a_once();
      end
    end

    // Latest request wins while busy; one drop counted
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    ts_a[0] = mk_ts(48'd1, 32'd1, 16'd0); req_a = 2'b01; tick(); req_a = 2'b00;
    wait_wr_a();
    ts_a[1] = mk_ts(48'd2, 32'd100, 16'd0); req_a = 2'b10; tick();
    ts_a[1] = mk_ts(48'd2, 32'd200, 16'd0); tick(); req_a = 2'b00;
    check("drop_cnt", {drop_a, pend_a}, {16'd1, 2'b10});
    ack_a_once();
    wait_wr_a();
    check("drop_wr", {last_a, wr_ns_a}, {1'b1, 30'd200});
    ack_a_once();
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_en_a) hi++;
    end
    check("drop_single", {32'(hi), wrc_a, pend_a}, {32'd0, 16'd2, 2'b00});

    // Fixed priority, timeout length and holdoff spacing on instance B
    ts_b[0] = mk_ts(48'd7, 32'd10, 16'd0); ts_b[1] = mk_ts(48'd8, 32'd20, 16'd0);
    req_b = 2'b11; tick(); req_b = 2'b00;
    check("fp_pend", pend_b, 2'b11);
    tick();
    check("fp_first", {wr_en_b, last_b, wr_ns_b, pend_b}, {1'b1, 1'b0, 30'd10, 2'b10});
    ts_b[0] = mk_ts(48'd7, 32'd777, 16'd0); req_b = 2'b01;
    hi = 0;
    while (wr_en_b && hi < 20) begin
      hi++; tick(); req_b = 2'b00;
    end
    check("to_len", {32'(hi), to_b, wrc_b}, {32'd8, 2'd1, 2'd0});
    lo = 0;
    while (!wr_en_b && lo < 20) begin
      lo++; tick();
    end
    check("ho_gap1", 32'(lo), 32'd4);
    check("fp_again", {last_b, wr_s_b, wr_ns_b}, {1'b0, 48'd7, 30'd777});
    ack_b = 1'b1; tick(); ack_b = 1'b0;
    check("ack_b1", {wr_en_b, wrc_b}, {1'b0, 2'd1});
    lo = 0;
    while (!wr_en_b && lo < 20) begin
      lo++; tick();
    end
    check("ho_gap2", 32'(lo), 32'd4);
    check("fp_ch1", {last_b, wr_s_b, wr_ns_b}, {1'b1, 48'd8, 30'd20});
    ack_b = 1'b1; tick(); ack_b = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("idle_b", {busy_b, wrc_b, pend_b}, {1'b0, 2'd2, 2'b00});

    // Invalid timestamps: boundary value, then saturation of a 2-bit counter
    ts_b[0] = mk_ts(48'd1, NSPS, 16'd0); req_b = 2'b01; tick(); req_b = 2'b00;
    check("inv_one", {inv_b, pend_b}, {2'd1, 2'b00});
    tick();
    check("inv_nowr", {wr_en_b, busy_b}, 2'b00);
    ts_b[1] = mk_ts(48'd1, 32'hFFFF_FFFF, 16'd0);
    for (int i = 0; i < 4; i++) begin
      req_b = 2'b10; tick();
    end
    req_b = 2'b00; tick();
    check("inv_sat", {inv_b, pend_b, busy_b}, {2'd3, 2'b00, 1'b0});

    // Stray ack outside WRITE, and a disabled channel's request
    ack_b = 1'b1; tick(); ack_b = 1'b0;
    check("stray_ack", {wrc_b, busy_b}, {2'd2, 1'b0});
    en_b = 2'b10; ts_b[0] = mk_ts(48'd4, 32'd4, 16'd0); req_b = 2'b01;
    tick(); req_b = 2'b00;
    check("disabled", {pend_b, inv_b, drop_b}, {2'b00, 2'd3, 2'd0});
    en_b = 2'b11;

    // Reset during a write discards everything
    ts_b[1] = mk_ts(48'd9, 32'd55, 16'd0); req_b = 2'b10; tick(); req_b = 2'b00;
    tick();
    check("pre_rst_wr", {wr_en_b, last_b}, {1'b1, 1'b1});
    ts_b[0] = mk_ts(48'd3, 32'd3, 16'd0); req_b = 2'b01; tick(); req_b = 2'b00;
    check("pre_rst_pend", pend_b, 2'b01);
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    check("mid_rst", {wr_en_b, busy_b, pend_b, last_b, wrc_b, drop_b, inv_b, to_b,
                      wr_s_b, wr_ns_b}, '0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wr_en_b) hi++;
    end
    check("post_rst", {32'(hi), pend_b}, {32'd0, 2'b00});

    // Randomized traffic on instance A
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req_a[0] = ($urandom_range(0, 9) < 3);
      req_a[1] = ($urandom_range(0, 9) < 3);
      ts_a[0] = rand_ts();
      ts_a[1] = rand_ts();
      ack_a = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) en_a = en_a ^ 2'(1 << $urandom_range(0, 1));
      rst_a = ($urandom_range(0, 299) == 0);
      tick();
    end
    req_a = '0; ack_a = 1'b0; rst_a = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
